// File: rtl/io_input_fifo_if.sv
// Handshake bundle between IO_fsm/CPU (master) and the stdin input FIFO (slave).
interface io_input_fifo_if #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 32
);
  logic [WIDTH-1:0]    wr_data;
  logic                wr_valid;
  logic                is_input;
  logic                rd_req;
  logic [WIDTH-1:0]    rd_data;
  logic                rd_valid;
  logic                rd_stall;
  logic [DEPTH_LOG2:0] count;
  logic                empty;
  logic                full;
  logic                overflow;

  modport master (
    output wr_data, wr_valid, is_input, rd_req,
    input  rd_data, rd_valid, rd_stall, count, empty, full, overflow
  );

  modport slave (
    input  wr_data, wr_valid, is_input, rd_req,
    output rd_data, rd_valid, rd_stall, count, empty, full, overflow
  );
endinterface

// File: rtl/io_input_fifo.sv
// Stdin word FIFO between IO_fsm and the CPU input instruction.
// Define IO_INPUT_FIFO_FWFT_EN for a first-word-fall-through read path (no FSM).
module io_input_fifo #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 32
) (
  input logic            clk,
  input logic            rstn,
  io_input_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wptr, r_rptr;
  logic                r_overflow;
  logic                w_empty, w_full, w_pop, w_push, w_wr_try;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (all equal).
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                    (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
  assign w_wr_try = bus.wr_valid & bus.is_input;
  assign w_push   = w_wr_try & (~w_full | w_pop);

  assign bus.count    = r_wptr - r_rptr;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_wr_try && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

`ifdef IO_INPUT_FIFO_FWFT_EN
  assign w_pop        = bus.rd_req & ~w_empty;
  assign bus.rd_data  = r_mem[r_rptr[DEPTH_LOG2-1:0]];
  assign bus.rd_valid = w_pop;
  assign bus.rd_stall = bus.rd_req & w_empty;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: if (bus.rd_req) begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // rd_data is only updated by a pop so it holds between reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_rd_data <= '0;
    else if (w_pop) r_rd_data <= r_mem[r_rptr[DEPTH_LOG2-1:0]];
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = (r_state == S_RESP);
  assign bus.rd_stall = bus.rd_req & ~bus.rd_valid;
`endif
endmodule

// File: tb/tb_io_input_fifo.sv
// Scoreboard bench for io_input_fifo: directed scenarios plus a randomized phase.
module tb_io_input_fifo;
  localparam int DL = 6, W = 32, DEPTH = 64;
`ifdef IO_INPUT_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;

  io_input_fifo_if #(.DEPTH_LOG2(DL), .WIDTH(W)) bus();
  io_input_fifo #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int dut_served = 0;
  logic [W-1:0] sb[$];   // accepted words in arrival order
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  bit m_resp = 1'b0;     // registered build: a response is owed this cycle

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    return FWFT ? (bus.rd_req && m_cnt > 0) : m_resp;
  endfunction

  // Reference: a word queue with a capacity; one pop per served request.
  task automatic model_update();
    bit pop;
    pop = bus.rd_req && m_cnt > 0 && (FWFT || !m_resp);
    if (!FWFT) m_resp = pop;
    if (bus.wr_valid && bus.is_input) begin
      if (m_cnt < DEPTH || pop) begin
        sb.push_back(bus.wr_data);
        m_cnt++;
      end else m_ovf = 1'b1;
    end
    if (pop) m_cnt--;
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt = 0; m_ovf = 1'b0; m_resp = 1'b0;
  endtask

  always @(negedge clk) begin
    bit v;
    if (rstn) begin
      v = m_valid();
      chk("rd_valid", bus.rd_valid, v);
      chk("rd_stall", bus.rd_stall, bus.rd_req && !v);
      chk("count", bus.count, m_cnt);
      chk("empty", bus.empty, m_cnt == 0);
      chk("full", bus.full, m_cnt == DEPTH);
      chk("overflow", bus.overflow, m_ovf);
      if (bus.rd_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_data: got %h expected no read at %0t", bus.rd_data, $time);
        end else chk("rd_data", bus.rd_data, sb.pop_front());
      end
    end
  end

  // One clock: model advances on the inputs held this cycle; a served request is dropped.
  task automatic step();
    bit v;
    @(negedge clk); #1;
    v = m_valid();
    if (bus.rd_valid) dut_served++;
    model_update();
    @(posedge clk); #1;
    if (v) bus.rd_req = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] w);
    bus.wr_data = w; bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic read_one();
    int s0;
    s0 = dut_served;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 10 && dut_served == s0; i++) step();
    chk("read_served", dut_served - s0, 1);
    bus.rd_req = 1'b0;
  endtask

  task automatic release_reset();
    bus.rd_req = 1'b0; bus.wr_valid = 1'b0; bus.is_input = 1'b1;
    @(negedge clk); #1 rstn = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #1 rstn = 1'b0;
    release_reset();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_overflow"}, bus.overflow, 1'b0);
    chk({tag, "_empty"}, bus.empty, 1'b1);
  endtask

  initial begin
    int lat;
    bus.wr_data = '0; bus.wr_valid = 1'b0; bus.is_input = 1'b1; bus.rd_req = 1'b0;
    #2;
    check_reset("reset");
    chk("reset_full", bus.full, 1'b0);
    release_reset();

    // 1: three words in, three reads out in order
    push(32'h11111111); push(32'h22222222); push(32'h33333333);
    chk("t1_count", bus.count, 3);
    repeat (3) read_one();

    // 2: program-load words are ignored
    bus.is_input = 1'b0;
    repeat (4) push($urandom);
    bus.is_input = 1'b1;
    chk("t2_count", bus.count, 0);
    chk("t2_empty", bus.empty, 1'b1);
    chk("t2_overflow", bus.overflow, 1'b0);

    // 3: request while empty, data arrives later
    bus.rd_req = 1'b1;
    repeat (5) step();
    chk("t3_stall", bus.rd_stall, 1'b1);
    push(32'hDEADBEEF);
    lat = 1;
    while (!bus.rd_valid && lat < 6) begin step(); lat++; end
    chk("t3_latency", lat, FWFT ? 1 : 2);
    chk("t3_data", bus.rd_data, 32'hDEADBEEF);
    step();

    // 4: overfill drops the extra word
    do_reset();
    for (int i = 0; i < DEPTH; i++) push($urandom);
    push(32'hBAD0BAD0);
    chk("t4_full", bus.full, 1'b1);
    chk("t4_count", bus.count, DEPTH);
    chk("t4_overflow", bus.overflow, 1'b1);
    repeat (DEPTH) read_one();
    chk("t4_empty", bus.empty, 1'b1);

    // 5: push and pop together while full, then a long wrapping stream
    do_reset();
    for (int i = 0; i < DEPTH; i++) push($urandom);
    bus.wr_data = 32'hCAFE0001; bus.wr_valid = 1'b1; bus.rd_req = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    chk("t5_count", bus.count, DEPTH);
    chk("t5_overflow", bus.overflow, 1'b0);
    if (bus.rd_valid) step();
    repeat (DEPTH) read_one();
    chk("t5_empty", bus.empty, 1'b1);
    for (int i = 0; i < 600; i++) begin
      bus.wr_valid = 1'($urandom % 2); bus.wr_data = $urandom;
      if (!bus.rd_req) bus.rd_req = 1'b1;
      step();
    end
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 2 * DEPTH && m_cnt > 0; i++) read_one();

    // 6: reset aborts a waiting read and a read being answered
    do_reset();
    bus.rd_req = 1'b1;
    repeat (2) step();
    #1 rstn = 1'b0;
    #1 check_reset("t6_wait");
    release_reset();
    for (int i = 0; i <= DEPTH; i++) push($urandom);
    bus.rd_req = 1'b1;
    #1;
    if (!bus.rd_valid) step();
    chk("t6_pre_valid", bus.rd_valid, 1'b1);
    rstn = 1'b0;
    #1 check_reset("t6_resp");
    release_reset();

    // randomized traffic: write-heavy then read-heavy
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 400; i++) begin
        bus.is_input = ($urandom % 8) != 0;
        bus.wr_valid = ($urandom % 100) < ((ph % 2 == 0) ? 80 : 25);
        bus.wr_data  = $urandom;
        if (!bus.rd_req) bus.rd_req = ($urandom % 100) < ((ph % 2 == 0) ? 30 : 85);
        step();
      end
    end
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 2 * DEPTH && m_cnt > 0; i++) read_one();
    chk("final_empty", bus.empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
